// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one single-cycle memory bus between a CPU (port 0) and a DMA/debug master (port 1).
// Optional feature macro MEM_BUS_ARB_RR_EN: round-robin contention instead of fixed port-0 priority.
module mem_bus_arbiter #(
    parameter int DBITS    = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [DBITS-1:0] addr0,
    input  logic [DBITS-1:0] addr1,
    input  logic [DBITS-1:0] wdata0,
    input  logic [DBITS-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [DBITS-1:0] rdata0,
    output logic [DBITS-1:0] rdata1,
    output logic [DBITS-1:0] memAddrBus,
    output logic [DBITS-1:0] dataBusOut,
    output logic             weBus,
    output logic             reBus,
    input  logic [DBITS-1:0] dataBusIn,
    output logic             busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [0:0]       state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [DBITS-1:0] rdata0_q, rdata0_d;
    logic [DBITS-1:0] rdata1_q, rdata1_d;

    logic             anyReq;
    logic             lastReq;
    logic             lastLock;
    logic             lockActive;
    logic             contendWinner;
    logic             winner;
    logic [HW-1:0]    holdNext;

    logic             selWe;
    logic [DBITS-1:0] selAddr;
    logic [DBITS-1:0] selWdata;

    // A lock only holds while the last owner keeps both req and lock high and its hold budget is not spent.
    always_comb begin
        anyReq     = req0 | req1;
        lastReq    = last_q ? req1 : req0;
        lastLock   = last_q ? lock1 : lock0;
        lockActive = lastReq && lastLock && (hold_q < HOLD_MAX);
`ifdef MEM_BUS_ARB_RR_EN
        contendWinner = ~last_q;
`else
        contendWinner = 1'b0;
`endif
        if (lockActive) begin
            winner = last_q;
        end else if (req0 && req1) begin
            winner = contendWinner;
        end else begin
            winner = req1;
        end

        if (winner == last_q) begin
            holdNext = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 1'b1;
        end else begin
            holdNext = HOLD_ONE;
        end
    end

    always_comb begin
        selWe    = gnt_q ? we1 : we0;
        selAddr  = gnt_q ? addr1 : addr0;
        selWdata = gnt_q ? wdata1 : wdata0;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        hold_d   = hold_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d = XFER;
                    gnt_d   = winner;
                    last_d  = winner;
                    hold_d  = holdNext;
                end
            end
            XFER: begin
                // Memory answers within the XFER cycle, so completion is captured on its closing edge.
                state_d = IDLE;
                if (gnt_q) begin
                    ack1_d = 1'b1;
                    if (!we1) begin
                        rdata1_d = dataBusIn;
                    end
                end else begin
                    ack0_d = 1'b1;
                    if (!we0) begin
                        rdata0_d = dataBusIn;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        memAddrBus = '0;
        dataBusOut = '0;
        weBus      = 1'b0;
        reBus      = 1'b0;
        if (state_q == XFER) begin
            memAddrBus = selAddr;
            weBus      = selWe;
            reBus      = ~selWe;
            dataBusOut = selWe ? selWdata : '0;
        end
    end

    // Reset abandons any transfer in flight; last_q = 1 lets port 0 win the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            hold_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = (state_q == XFER);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic against a transfer-level model.
module tb_mem_bus_arbiter;

    localparam int DBITS    = 32;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             reset;
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [DBITS-1:0] addr0, addr1, wdata0, wdata1;
    logic             ack0, ack1, weBus, reBus, busy;
    logic [DBITS-1:0] rdata0, rdata1, memAddrBus, dataBusOut, dataBusIn;

    int compared   = 0;
    int mismatched = 0;

    // Transfer-level reference model state
    bit               mBusy;
    bit               mPort;
    bit               mLast;
    bit               mAck0;
    bit               mAck1;
    int               mHold;
    logic [DBITS-1:0] mRdata0;
    logic [DBITS-1:0] mRdata1;

    mem_bus_arbiter #(
        .DBITS(DBITS),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req0(req0),
        .req1(req1),
        .we0(we0),
        .we1(we1),
        .lock0(lock0),
        .lock1(lock1),
        .addr0(addr0),
        .addr1(addr1),
        .wdata0(wdata0),
        .wdata1(wdata1),
        .ack0(ack0),
        .ack1(ack1),
        .rdata0(rdata0),
        .rdata1(rdata1),
        .memAddrBus(memAddrBus),
        .dataBusOut(dataBusOut),
        .weBus(weBus),
        .reBus(reBus),
        .dataBusIn(dataBusIn),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of address; 0x100 holds the well-known read pattern.
    function automatic logic [DBITS-1:0] memRead(input logic [DBITS-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign dataBusIn = memRead(memAddrBus);

    function automatic bit modelPick();
        bit lastReq;
        bit lastLock;
        lastReq  = mLast ? req1 : req0;
        lastLock = mLast ? lock1 : lock0;
        if (lastReq && lastLock && mHold < MAX_HOLD) return mLast;
        if (req0 && req1) begin
`ifdef MEM_BUS_ARB_RR_EN
            return !mLast;
`else
            return 1'b0;
`endif
        end
        return req1;
    endfunction

    task automatic modelStep();
        bit p;
        if (!reset) begin
            mBusy   = 0;
            mPort   = 0;
            mLast   = 1;
            mHold   = 0;
            mAck0   = 0;
            mAck1   = 0;
            mRdata0 = '0;
            mRdata1 = '0;
        end else if (mBusy) begin
            mAck0 = !mPort;
            mAck1 = mPort;
            if (!mPort && !we0) mRdata0 = memRead(addr0);
            if (mPort && !we1) mRdata1 = memRead(addr1);
            mBusy = 0;
        end else begin
            mAck0 = 0;
            mAck1 = 0;
            if (req0 || req1) begin
                p     = modelPick();
                mHold = (p == mLast) ? ((mHold < MAX_HOLD) ? mHold + 1 : MAX_HOLD) : 1;
                mLast = p;
                mPort = p;
                mBusy = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic clearInputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic applyReset();
        clearInputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 0;
        tick();
        tick();
        @(negedge clk);
        compared++;
        if ({busy, ack0, ack1, weBus, reBus} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", {busy, ack0, ack1, weBus, reBus}, 5'b0);
        end
        compared++;
        if ({rdata0, rdata1, memAddrBus, dataBusOut} !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h expected 0", {rdata0, rdata1, memAddrBus, dataBusOut});
        end
        reset = 1;
        req0  = 1; we0 = 0; addr0 = 32'h100;
        tick();
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || memAddrBus !== 32'h100) begin
            mismatched++;
            $display("[TB] FAIL first_after_reset: got busy=%b addr=%h expected busy=1 addr=00000100", busy, memAddrBus);
        end
        tick();
        req0 = 0;
        tick();
    endtask

    task automatic test_single_read();
        applyReset();
        req0 = 1; we0 = 0; addr0 = 32'h100;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_cycle0_busy: got %b expected 0", busy);
        end
        tick();
        @(negedge clk);
        compared++;
        if ({busy, reBus, weBus} !== 3'b110) begin
            mismatched++;
            $display("[TB] FAIL read_strobes: got %b expected 110", {busy, reBus, weBus});
        end
        compared++;
        if (memAddrBus !== 32'h100 || dataBusOut !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL read_bus: got addr=%h data=%h expected addr=00000100 data=00000000", memAddrBus, dataBusOut);
        end
        tick();
        req0 = 0;
        @(negedge clk);
        compared++;
        if ({ack0, ack1, busy} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL read_ack: got %b expected 100", {ack0, ack1, busy});
        end
        compared++;
        if (rdata0 !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL read_rdata0: got %h expected deadbeef", rdata0);
        end
        tick();
        @(negedge clk);
        compared++;
        if (ack0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_ack_pulse: got %b expected 0", ack0);
        end
    endtask

    task automatic test_single_write();
        logic [DBITS-1:0] prev1;
        prev1 = memRead(32'h300);
        req1 = 1; we1 = 0; addr1 = 32'h300;
        tick();
        tick();
        req1 = 0;
        @(negedge clk);
        compared++;
        if (rdata1 !== prev1) begin
            mismatched++;
            $display("[TB] FAIL write_pre_read: got %h expected %h", rdata1, prev1);
        end
        tick();
        req1 = 1; we1 = 1; addr1 = 32'h2000; wdata1 = 32'h55AA;
        tick();
        @(negedge clk);
        compared++;
        if ({busy, weBus, reBus} !== 3'b110) begin
            mismatched++;
            $display("[TB] FAIL write_strobes: got %b expected 110", {busy, weBus, reBus});
        end
        compared++;
        if (dataBusOut !== 32'h55AA || memAddrBus !== 32'h2000) begin
            mismatched++;
            $display("[TB] FAIL write_bus: got addr=%h data=%h expected addr=00002000 data=000055aa", memAddrBus, dataBusOut);
        end
        tick();
        req1 = 0; we1 = 0;
        @(negedge clk);
        compared++;
        if ({ack0, ack1} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL write_ack: got %b expected 01", {ack0, ack1});
        end
        compared++;
        if (rdata1 !== prev1 || rdata0 !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL write_rdata_hold: got r0=%h r1=%h expected r0=deadbeef r1=%h", rdata0, rdata1, prev1);
        end
        tick();
    endtask

    task automatic test_contention();
        bit expOrder[5];
        int seen;
        int budget;
`ifdef MEM_BUS_ARB_RR_EN
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        expOrder = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        applyReset();
        req0 = 1; we0 = 0; addr0 = 32'h400;
        req1 = 1; we1 = 0; addr1 = 32'h800;
        seen   = 0;
        budget = 40;
        while (seen < 5 && budget > 0) begin
            tick();
            budget--;
            @(negedge clk);
            if (ack0 || ack1) begin
                compared++;
                if (ack1 !== expOrder[seen]) begin
                    mismatched++;
                    $display("[TB] FAIL contention_grant%0d: got port %b expected port %b", seen, ack1, expOrder[seen]);
                end
                seen++;
                if (seen == 4) req0 = 0;
            end
        end
        compared++;
        if (seen != 5) begin
            mismatched++;
            $display("[TB] FAIL contention_timeout: got %0d acks expected 5", seen);
        end
        clearInputs();
        tick();
    endtask

    task automatic test_lock();
        bit expA[5];
        bit expB[5];
        int seen;
        int budget;
`ifdef MEM_BUS_ARB_RR_EN
        expA = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        expA = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        expB = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        applyReset();
        req0 = 1; lock0 = 1; addr0 = 32'h500;
        req1 = 1; addr1 = 32'h600;
        seen   = 0;
        budget = 40;
        while (seen < 5 && budget > 0) begin
            tick();
            budget--;
            @(negedge clk);
            if (ack0 || ack1) begin
                compared++;
                if (ack1 !== expA[seen]) begin
                    mismatched++;
                    $display("[TB] FAIL lock_cpu_grant%0d: got port %b expected port %b", seen, ack1, expA[seen]);
                end
                seen++;
            end
        end
        compared++;
        if (seen != 5) begin
            mismatched++;
            $display("[TB] FAIL lock_cpu_timeout: got %0d acks expected 5", seen);
        end

        applyReset();
        req1 = 1; lock1 = 1; addr1 = 32'h700;
        addr0 = 32'h100;
        seen   = 0;
        budget = 40;
        while (seen < 5 && budget > 0) begin
            tick();
            budget--;
            @(negedge clk);
            if (ack0 || ack1) begin
                compared++;
                if (ack1 !== expB[seen]) begin
                    mismatched++;
                    $display("[TB] FAIL lock_dma_grant%0d: got port %b expected port %b", seen, ack1, expB[seen]);
                end
                seen++;
                if (seen == 1) req0 = 1;
            end
        end
        compared++;
        if (seen != 5) begin
            mismatched++;
            $display("[TB] FAIL lock_dma_timeout: got %0d acks expected 5", seen);
        end
        clearInputs();
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        applyReset();
        req1 = 1; we1 = 0; addr1 = 32'h900;
        tick();
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || memAddrBus !== 32'h900) begin
            mismatched++;
            $display("[TB] FAIL midreset_xfer: got busy=%b addr=%h expected busy=1 addr=00000900", busy, memAddrBus);
        end
        reset = 0;
        req0  = 1; we0 = 0; addr0 = 32'hA00;
        tick();
        @(negedge clk);
        compared++;
        if ({ack0, ack1, busy, weBus, reBus} !== 5'b0 || memAddrBus !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset_abandon: got ctrl=%b addr=%h expected ctrl=00000 addr=00000000",
                     {ack0, ack1, busy, weBus, reBus}, memAddrBus);
        end
        reset = 1;
        tick();
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || memAddrBus !== 32'hA00) begin
            mismatched++;
            $display("[TB] FAIL midreset_first_winner: got busy=%b addr=%h expected busy=1 addr=00000a00", busy, memAddrBus);
        end
        tick();
        req0 = 0;
        @(negedge clk);
        compared++;
        if ({ack0, ack1} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL midreset_ack: got %b expected 10", {ack0, ack1});
        end
        clearInputs();
        tick();
    endtask

    task automatic test_idle_bus();
        applyReset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            compared++;
            if ({busy, weBus, reBus} !== 3'b000 || memAddrBus !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL idle_bus cycle %0d: got ctrl=%b addr=%h expected ctrl=000 addr=00000000",
                         c, {busy, weBus, reBus}, memAddrBus);
            end
            tick();
        end
    endtask

    task automatic test_random(input int cycles);
        logic             expWe;
        logic [DBITS-1:0] expAddr;
        logic [DBITS-1:0] expData;
        applyReset();
        for (int c = 0; c < cycles; c++) begin
            // Masters keep a pending request stable and only move on once the model says it completed.
            if (!req0 || mAck0) begin
                req0 = ($urandom_range(0, 1) == 1);
                if (req0) begin
                    we0    = $urandom_range(0, 1);
                    lock0  = ($urandom_range(0, 2) == 0);
                    addr0  = 32'($urandom_range(0, 15)) << 8;
                    wdata0 = $urandom;
                end
            end
            if (!req1 || mAck1) begin
                req1 = ($urandom_range(0, 1) == 1);
                if (req1) begin
                    we1    = $urandom_range(0, 1);
                    lock1  = ($urandom_range(0, 2) == 0);
                    addr1  = 32'($urandom_range(0, 15)) << 8;
                    wdata1 = $urandom;
                end
            end
            @(negedge clk);
            expWe   = mBusy && (mPort ? we1 : we0);
            expAddr = mBusy ? (mPort ? addr1 : addr0) : '0;
            expData = expWe ? (mPort ? wdata1 : wdata0) : '0;
            compared++;
            if ({busy, weBus, reBus, ack0, ack1} !== {mBusy, expWe, mBusy && !expWe, mAck0, mAck1}) begin
                mismatched++;
                $display("[TB] FAIL rand_ctrl cycle %0d: got %b expected %b", c,
                         {busy, weBus, reBus, ack0, ack1}, {mBusy, expWe, mBusy && !expWe, mAck0, mAck1});
            end
            compared++;
            if (memAddrBus !== expAddr) begin
                mismatched++;
                $display("[TB] FAIL rand_addr cycle %0d: got %h expected %h", c, memAddrBus, expAddr);
            end
            compared++;
            if (dataBusOut !== expData) begin
                mismatched++;
                $display("[TB] FAIL rand_wdata cycle %0d: got %h expected %h", c, dataBusOut, expData);
            end
            compared++;
            if (rdata0 !== mRdata0 || rdata1 !== mRdata1) begin
                mismatched++;
                $display("[TB] FAIL rand_rdata cycle %0d: got %h/%h expected %h/%h", c, rdata0, rdata1, mRdata0, mRdata1);
            end
            compared++;
            if (ack0 && ack1) begin
                mismatched++;
                $display("[TB] FAIL rand_ack_exclusive cycle %0d: got 11 expected at most one", c);
            end
            tick();
        end
        clearInputs();
        tick();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 0;
        clearInputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_lock();
        test_reset_mid_xfer();
        test_idle_bus();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
